clock_mode_ctrl: RTL and testbench

Mode and alarm controller for the digital clock. It routes the shared debounced set keys either to the time counter or to its own alarm registers, and owns the alarm time and enable. It compares the running time against the alarm and drives the ring output through a ring/snooze state machine. It sits between the key debouncers and the time counter, and runs from the system clock with a 1 Hz tick enable.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/alarm_ring_fsm.sv | 96 +++++++++
 rtl/clock_mode_ctrl.sv | 135 +++++++++++++
 tb/tb_clock_mode_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and constants for the clock mode/alarm controller.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_RSVD      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ALM_IDLE    = 2'd0,
    ALM_RINGING = 2'd1,
    ALM_SNOOZE  = 2'd2
  } alm_state_e;

  localparam int unsigned HOURS_PER_DAY = 24;
  localparam int unsigned MIN_PER_HOUR  = 60;

  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input int unsigned modulus);
    return (v == 8'(modulus - 1)) ? 8'd0 : v + 8'd1;
  endfunction

endpackage

// File: rtl/alarm_ring_fsm.sv
// Ring/snooze state machine with its seconds counter.
// Optional snooze path enabled by macro CLOCK_SNOOZE_EN.
module alarm_ring_fsm
  import clock_pkg::*;
#(
  parameter int unsigned RING_SEC = 60
`ifdef CLOCK_SNOOZE_EN
  , parameter int unsigned SNOOZE_SEC = 300
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trigger_i,
  input  logic tick_1hz_i,
  input  logic key_stop_i,
  input  logic force_idle_i,
  output logic ring_o
);

`ifdef CLOCK_SNOOZE_EN
  localparam int CNT_W = 16;
`else
  localparam int CNT_W = 8;
`endif

  alm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ALM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // key_stop is checked before tick so a coincident tick is never counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_idle_i) begin
      state_d = ALM_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ALM_IDLE: begin
          if (trigger_i) begin
            state_d = ALM_RINGING;
            cnt_d   = '0;
          end
        end
        ALM_RINGING: begin
          if (key_stop_i) begin
`ifdef CLOCK_SNOOZE_EN
            state_d = ALM_SNOOZE;
`else
            state_d = ALM_IDLE;
`endif
            cnt_d   = '0;
          end else if (tick_1hz_i) begin
            if (cnt_q == CNT_W'(RING_SEC - 1)) begin
              state_d = ALM_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
`ifdef CLOCK_SNOOZE_EN
        ALM_SNOOZE: begin
          if (key_stop_i) begin
            state_d = ALM_IDLE;
            cnt_d   = '0;
          end else if (tick_1hz_i) begin
            if (cnt_q == CNT_W'(SNOOZE_SEC - 1)) begin
              state_d = ALM_RINGING;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d = ALM_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign ring_o = (state_q == ALM_RINGING);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode FSM, set-key routing, alarm registers and match edge detect for the clock.
// Snooze behaviour of the ring FSM is enabled by macro CLOCK_SNOOZE_EN.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_1hz_i,
  input  logic       key_mode_i,
  input  logic       key_hour_up_i,
  input  logic       key_min_up_i,
  input  logic       key_sec_up_i,
  input  logic       key_stop_i,
  input  logic [7:0] hour_i,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  output logic       inc_hour_o,
  output logic       inc_min_o,
  output logic       inc_sec_o,
  output logic [7:0] alarm_hour_o,
  output logic [7:0] alarm_min_o,
  output logic       alarm_en_o,
  output logic [1:0] mode_o,
  output logic       ring_o
);

  if (RING_SEC < 1 || RING_SEC > 255 || SNOOZE_SEC < 1 || SNOOZE_SEC > 65535) begin : g_param_err
    $error("clock_mode_ctrl: RING_SEC or SNOOZE_SEC out of range");
  end

  mode_e       mode_q, mode_d;
  logic [7:0]  alarm_hour_q, alarm_hour_d;
  logic [7:0]  alarm_min_q, alarm_min_d;
  logic        alarm_en_q, alarm_en_d;
  logic        inc_hour_q, inc_hour_d;
  logic        inc_min_q, inc_min_d;
  logic        inc_sec_q, inc_sec_d;
  logic        match_q, match_d;
  logic        match_dly_q;
  logic        keys_live;
  logic        trigger;
  logic        force_idle;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q       <= MODE_RUN;
      alarm_hour_q <= 8'd7;
      alarm_min_q  <= 8'd0;
      alarm_en_q   <= 1'b0;
      inc_hour_q   <= 1'b0;
      inc_min_q    <= 1'b0;
      inc_sec_q    <= 1'b0;
      match_q      <= 1'b0;
      match_dly_q  <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_en_q   <= alarm_en_d;
      inc_hour_q   <= inc_hour_d;
      inc_min_q    <= inc_min_d;
      inc_sec_q    <= inc_sec_d;
      match_q      <= match_d;
      match_dly_q  <= match_q;
    end
  end

  // A mode press swallows any up key in the same cycle.
  assign keys_live = ~key_mode_i;

  always_comb begin
    mode_d       = mode_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_en_d   = alarm_en_q;
    inc_hour_d   = 1'b0;
    inc_min_d    = 1'b0;
    inc_sec_d    = 1'b0;

    if (mode_q == MODE_RSVD) begin
      mode_d = MODE_RUN;
    end else if (key_mode_i) begin
      case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_TIME;
        MODE_SET_TIME: mode_d = MODE_SET_ALARM;
        default:       mode_d = MODE_RUN;
      endcase
    end

    if (keys_live && mode_q == MODE_SET_TIME) begin
      inc_hour_d = key_hour_up_i;
      inc_min_d  = key_min_up_i;
      inc_sec_d  = key_sec_up_i;
    end

    if (keys_live && mode_q == MODE_SET_ALARM) begin
      if (key_hour_up_i) alarm_hour_d = wrap_inc(alarm_hour_q, HOURS_PER_DAY);
      if (key_min_up_i)  alarm_min_d  = wrap_inc(alarm_min_q, MIN_PER_HOUR);
      if (key_sec_up_i)  alarm_en_d   = ~alarm_en_q;
    end
  end

  assign match_d = (mode_q == MODE_RUN) && alarm_en_q &&
                   (hour_i == alarm_hour_q) && (min_i == alarm_min_q) && (sec_i == 8'd0);

  assign trigger    = match_q & ~match_dly_q;
  assign force_idle = key_mode_i | ~alarm_en_q;

  alarm_ring_fsm #(
    .RING_SEC   (RING_SEC)
`ifdef CLOCK_SNOOZE_EN
    , .SNOOZE_SEC (SNOOZE_SEC)
`endif
  ) u_ring_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .trigger_i    (trigger),
    .tick_1hz_i   (tick_1hz_i),
    .key_stop_i   (key_stop_i),
    .force_idle_i (force_idle),
    .ring_o       (ring_o)
  );

  assign inc_hour_o   = inc_hour_q;
  assign inc_min_o    = inc_min_q;
  assign inc_sec_o    = inc_sec_q;
  assign alarm_hour_o = alarm_hour_q;
  assign alarm_min_o  = alarm_min_q;
  assign alarm_en_o   = alarm_en_q;
  assign mode_o       = mode_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: vector table, directed alarm sequences, random run vs reference model.
module tb_clock_mode_ctrl;

  localparam int RING   = 60;
  localparam int SNOOZE = 300;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick_1hz_i = 1'b0;
  logic       key_mode_i = 1'b0, key_hour_up_i = 1'b0, key_min_up_i = 1'b0;
  logic       key_sec_up_i = 1'b0, key_stop_i = 1'b0;
  logic [7:0] hour_i = 8'd12, min_i = 8'd30, sec_i = 8'd15;
  logic       inc_hour_o, inc_min_o, inc_sec_o;
  logic [7:0] alarm_hour_o, alarm_min_o;
  logic       alarm_en_o;
  logic [1:0] mode_o;
  logic       ring_o;

  int checks = 0;
  int errors = 0;

  clock_mode_ctrl #(.RING_SEC(RING), .SNOOZE_SEC(SNOOZE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_1hz_i(tick_1hz_i),
    .key_mode_i(key_mode_i), .key_hour_up_i(key_hour_up_i),
    .key_min_up_i(key_min_up_i), .key_sec_up_i(key_sec_up_i),
    .key_stop_i(key_stop_i), .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
    .inc_hour_o(inc_hour_o), .inc_min_o(inc_min_o), .inc_sec_o(inc_sec_o),
    .alarm_hour_o(alarm_hour_o), .alarm_min_o(alarm_min_o),
    .alarm_en_o(alarm_en_o), .mode_o(mode_o), .ring_o(ring_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: mode as 0..2, alarm as a named state plus seconds remaining.
  int m_mode, m_ah, m_am, m_st, m_rem;
  bit m_en, m_m1, m_m2, m_ih, m_im, m_is;
  localparam int ST_IDLE = 0, ST_RING = 1, ST_SNZ = 2;

  task automatic model_step();
    bit now, trig, force_idle;
    if (rst_i) begin
      m_mode = 0; m_ah = 7; m_am = 0; m_en = 0; m_st = ST_IDLE; m_rem = 0;
      m_m1 = 0; m_m2 = 0; m_ih = 0; m_im = 0; m_is = 0;
      return;
    end
    now  = (m_mode == 0) && m_en && (int'(hour_i) == m_ah) && (int'(min_i) == m_am) && (sec_i == 0);
    trig = m_m1 && !m_m2;
    force_idle = key_mode_i || !m_en;
    if (force_idle) m_st = ST_IDLE;
    else if (m_st == ST_IDLE) begin
      if (trig) begin m_st = ST_RING; m_rem = RING; end
    end else if (m_st == ST_RING) begin
      if (key_stop_i) begin
`ifdef CLOCK_SNOOZE_EN
        m_st = ST_SNZ; m_rem = SNOOZE;
`else
        m_st = ST_IDLE;
`endif
      end else if (tick_1hz_i) begin
        m_rem--;
        if (m_rem == 0) m_st = ST_IDLE;
      end
    end else begin
      if (key_stop_i) m_st = ST_IDLE;
      else if (tick_1hz_i) begin
        m_rem--;
        if (m_rem == 0) begin m_st = ST_RING; m_rem = RING; end
      end
    end
    m_m2 = m_m1;
    m_m1 = now;
    m_ih = (m_mode == 1) && !key_mode_i && key_hour_up_i;
    m_im = (m_mode == 1) && !key_mode_i && key_min_up_i;
    m_is = (m_mode == 1) && !key_mode_i && key_sec_up_i;
    if (m_mode == 2 && !key_mode_i) begin
      if (key_hour_up_i) m_ah = (m_ah + 1) % 24;
      if (key_min_up_i)  m_am = (m_am + 1) % 60;
      if (key_sec_up_i)  m_en = !m_en;
    end
    if (key_mode_i) m_mode = (m_mode + 1) % 3;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    tick_1hz_i = 0; key_mode_i = 0; key_hour_up_i = 0;
    key_min_up_i = 0; key_sec_up_i = 0; key_stop_i = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_1hz_i = 1; step(); step();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mode"}, mode_o, 0);
    chk({tag, "_ah"}, alarm_hour_o, 7);
    chk({tag, "_am"}, alarm_min_o, 0);
    chk({tag, "_en"}, alarm_en_o, 0);
    chk({tag, "_ring"}, ring_o, 0);
    chk({tag, "_inc"}, {inc_hour_o, inc_min_o, inc_sec_o}, 0);
  endtask

  typedef struct {
    bit km, hu, mu, su;
    int e_mode;
    bit e_ih, e_im, e_is;
    int e_ah, e_am;
    bit e_en;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          km hu mu su mode ih im is ah am en
    tbl[0]  = '{0, 0, 0, 0, 0,   0, 0, 0, 7, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0,   0, 0, 0, 7, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1,   0, 0, 0, 7, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 1,   0, 1, 0, 7, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 1,   0, 0, 0, 7, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 1,   1, 0, 0, 7, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 1,   0, 0, 1, 7, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 2,   0, 0, 0, 7, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 2,   0, 0, 0, 8, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 2,   0, 0, 0, 8, 1, 0};
    tbl[10] = '{0, 0, 0, 1, 2,   0, 0, 0, 8, 1, 1};
    tbl[11] = '{0, 0, 0, 1, 2,   0, 0, 0, 8, 1, 0};
    tbl[12] = '{1, 0, 1, 0, 0,   0, 0, 0, 8, 1, 0};
    tbl[13] = '{0, 1, 0, 0, 0,   0, 0, 0, 8, 1, 0};
    tbl[14] = '{1, 0, 0, 0, 1,   0, 0, 0, 8, 1, 0};
    tbl[15] = '{1, 0, 0, 0, 2,   0, 0, 0, 8, 1, 0};
    tbl[16] = '{1, 0, 0, 0, 0,   0, 0, 0, 8, 1, 0};

    @(negedge clk_i);
    rst_i = 1; step(); step(); rst_i = 0;
    chk_reset("reset");

    for (int v = 0; v < 17; v++) begin
      key_mode_i = tbl[v].km; key_hour_up_i = tbl[v].hu;
      key_min_up_i = tbl[v].mu; key_sec_up_i = tbl[v].su;
      step();
      chk($sformatf("vec%0d_mode", v), mode_o, tbl[v].e_mode);
      chk($sformatf("vec%0d_inc_hour", v), inc_hour_o, tbl[v].e_ih);
      chk($sformatf("vec%0d_inc_min", v), inc_min_o, tbl[v].e_im);
      chk($sformatf("vec%0d_inc_sec", v), inc_sec_o, tbl[v].e_is);
      chk($sformatf("vec%0d_ah", v), alarm_hour_o, tbl[v].e_ah);
      chk($sformatf("vec%0d_am", v), alarm_min_o, tbl[v].e_am);
      chk($sformatf("vec%0d_en", v), alarm_en_o, tbl[v].e_en);
      chk($sformatf("vec%0d_ring", v), ring_o, 0);
    end

    // Alarm register wrap and arming.
    rst_i = 1; step(); rst_i = 0;
    key_mode_i = 1; step(); key_mode_i = 1; step();
    chk("to_set_alarm", mode_o, 2);
    repeat (16) begin key_hour_up_i = 1; step(); end
    chk("ah_23", alarm_hour_o, 23);
    key_hour_up_i = 1; step();
    chk("ah_wrap", alarm_hour_o, 0);
    repeat (59) begin key_min_up_i = 1; step(); end
    chk("am_59", alarm_min_o, 59);
    key_min_up_i = 1; step();
    chk("am_wrap", alarm_min_o, 0);
    repeat (7) begin key_hour_up_i = 1; step(); end
    chk("ah_7", alarm_hour_o, 7);
    key_sec_up_i = 1; step();
    chk("en_set", alarm_en_o, 1);
    key_mode_i = 1; step();
    chk("back_run", mode_o, 0);

    // Match -> ring latency, duration and no retrigger while held.
    hour_i = 7; min_i = 0; sec_i = 0;
    step(); chk("ring_lat1", ring_o, 0);
    step(); chk("ring_lat2", ring_o, 1);
    repeat (5) step();
    chk("ring_held", ring_o, 1);
    ticks(RING - 1);
    chk("ring_before_timeout", ring_o, 1);
    tick_1hz_i = 1; step();
    chk("ring_timeout", ring_o, 0);
    repeat (10) step();
    chk("no_retrigger", ring_o, 0);

    // New matching minute, then stop (with coincident tick).
    sec_i = 1; step(); sec_i = 0; step(); step();
    chk("retrigger", ring_o, 1);
    key_stop_i = 1; tick_1hz_i = 1; step();
    chk("stop_ring", ring_o, 0);
`ifdef CLOCK_SNOOZE_EN
    ticks(SNOOZE - 1);
    chk("snooze_hold", ring_o, 0);
    tick_1hz_i = 1; step();
    chk("snooze_rering", ring_o, 1);
    key_stop_i = 1; step();
    chk("stop_again", ring_o, 0);
    key_stop_i = 1; step();
    ticks(SNOOZE);
    chk("stop_in_snooze", ring_o, 0);
`else
    ticks(SNOOZE);
    chk("stop_idle", ring_o, 0);
`endif

    // Trigger with coincident stop, then reset mid-ring.
    sec_i = 1; step(); sec_i = 0; step();
    key_stop_i = 1; step();
    chk("trig_beats_stop", ring_o, 1);
    rst_i = 1; step(); rst_i = 0;
    chk_reset("rst_mid_ring");

    // Mode press while ringing.
    key_mode_i = 1; step(); key_mode_i = 1; step();
    key_sec_up_i = 1; step();
    key_mode_i = 1; step();
    step(); step();
    chk("ring_again", ring_o, 1);
    key_mode_i = 1; step();
    chk("mode_kills_ring", ring_o, 0);
    chk("mode_kills_ring_mode", mode_o, 1);

    // Randomized run against the model.
    rst_i = 1; step(); rst_i = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 8 == 0) begin
        hour_i = ($urandom % 2) ? 8'(m_ah) : 8'($urandom % 24);
        min_i  = ($urandom % 2) ? 8'(m_am) : 8'($urandom % 60);
        sec_i  = ($urandom % 3 == 0) ? 8'd0 : 8'($urandom % 60);
      end
      key_mode_i    = ($urandom % 40 == 0);
      key_hour_up_i = ($urandom % 5 == 0);
      key_min_up_i  = ($urandom % 5 == 0);
      key_sec_up_i  = ($urandom % 6 == 0);
      key_stop_i    = ($urandom % 25 == 0);
      tick_1hz_i    = ($urandom % 3 == 0);
      step();
      chk("rnd_mode", mode_o, m_mode);
      chk("rnd_inc", {inc_hour_o, inc_min_o, inc_sec_o}, {m_ih, m_im, m_is});
      chk("rnd_ah", alarm_hour_o, m_ah);
      chk("rnd_am", alarm_min_o, m_am);
      chk("rnd_en", alarm_en_o, m_en);
      chk("rnd_ring", ring_o, m_st == ST_RING);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
